ddr_rom_cache: RTL and testbench

Read-only line cache in front of the shared DDR port: converts single 16-bit ROM fetches from a game-side client into 4-beat 64-bit DDR burst reads and keeps a small direct-mapped store of recently fetched lines. Sits directly upstream of the DDR port arbiter and drives one of its client-side `ddr_if` ports. Use of the port is requested only on a miss, via `acquire`.

---
 rtl/ddr_rom_cache_if.sv | 24 ++
 rtl/ddr_rom_cache.sv | 160 ++++++++++++++++
 tb/tb_ddr_rom_cache.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_rom_cache_if.sv
// Client-side DDR port bundle between a requester and the DDR port arbiter.
// to_host is the requester side; from_host is the arbiter side.
interface ddr_if;
   logic        acquire;
   logic        read;
   logic        write;
   logic [31:0] addr;
   logic [63:0] wdata;
   logic [7:0]  byteenable;
   logic [7:0]  burstcnt;
   logic        busy;
   logic [63:0] rdata;
   logic        rdata_ready;

   modport to_host (
      output acquire, read, write, addr, wdata, byteenable, burstcnt,
      input  busy, rdata, rdata_ready
   );

   modport from_host (
      input  acquire, read, write, addr, wdata, byteenable, burstcnt,
      output busy, rdata, rdata_ready
   );
endinterface

// File: rtl/ddr_rom_cache.sv
// Direct-mapped 4 x 32-byte read-only line cache turning 16-bit ROM fetches into 4-beat DDR bursts.
// Optional DDR_ROM_CACHE_CRITICAL_WORD_EN: fill starts at the requested beat and answers after it.
module ddr_rom_cache #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          ADDR_W    = 24
) (
   input  logic              clk,
   input  logic              reset_n,
   ddr_if.to_host            ddr,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr,
   input  logic              invalidate,
   output logic [15:0]       data,
   output logic              ready
);
   localparam int TAG_W = ADDR_W - 7;

   typedef enum logic [2:0] {IDLE, ACQ, ISSUE, FILL, RESP} state_t;

`ifdef DDR_ROM_CACHE_CRITICAL_WORD_EN
   localparam state_t FILL_DONE = IDLE;
`else
   localparam state_t FILL_DONE = RESP;
`endif

   state_t            state_q, state_d;
   logic [3:0]        valid_q;
   logic [TAG_W-1:0]  tag_mem  [4];
   logic [63:0]       line_mem [16];
   logic [ADDR_W-1:0] lat_addr;
   logic [1:0]        beat_cnt_q;
   logic [1:0]        beat_num_q;
   logic              pend_q;
   logic [15:0]       data_q;

   logic [1:0]        req_idx, req_beat, req_hw;
   logic [TAG_W-1:0]  req_tag;
   logic [1:0]        lat_idx, lat_beat, lat_hw;
   logic [TAG_W-1:0]  lat_tag;
   logic [1:0]        start_beat;
   logic [31:0]       line_off;
   logic              hit, start_hit, start_miss, busy_state, beat_in, last_beat;
   logic              acquire_c, read_c, ready_c;
   logic              unused_bits;

   function automatic logic [15:0] hw_sel(input logic [63:0] w, input logic [1:0] h);
      return w[{h, 4'b0000} +: 16];
   endfunction

   assign req_idx  = addr[6:5];
   assign req_beat = addr[4:3];
   assign req_hw   = addr[2:1];
   assign req_tag  = addr[ADDR_W-1:7];
   assign lat_idx  = lat_addr[6:5];
   assign lat_beat = lat_addr[4:3];
   assign lat_hw   = lat_addr[2:1];
   assign lat_tag  = lat_addr[ADDR_W-1:7];

   // A request sampled together with invalidate must see every line as invalid.
   assign hit        = valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !invalidate;
   assign start_hit  = (state_q == IDLE) && req && hit;
   assign start_miss = (state_q == IDLE) && req && !hit;
   assign busy_state = state_q inside {ACQ, ISSUE, FILL};
   assign beat_in    = (state_q == FILL) && ddr.rdata_ready;
   assign last_beat  = beat_in && (beat_num_q == 2'd3);

`ifdef DDR_ROM_CACHE_CRITICAL_WORD_EN
   logic early_rdy_q;
   assign start_beat = req_beat;
   assign line_off   = 32'({lat_addr[ADDR_W-1:3], 3'b000});
`else
   assign start_beat = 2'd0;
   assign line_off   = 32'({lat_addr[ADDR_W-1:5], 5'b00000});
`endif

   assign ddr.addr       = BASE_ADDR + line_off;
   assign ddr.write      = 1'b0;
   assign ddr.wdata      = '0;
   assign ddr.byteenable = 8'hFF;
   assign ddr.burstcnt   = 8'd4;
   assign ddr.acquire    = acquire_c;
   assign ddr.read       = read_c;
   assign ready          = ready_c;
   assign data           = data_q;
   assign unused_bits    = addr[0] ^ lat_addr[0];

   always_comb begin
      state_d   = state_q;
      acquire_c = busy_state;
      read_c    = 1'b0;
      ready_c   = 1'b0;
      unique case (state_q)
         IDLE:    if (req) state_d = hit ? RESP : ACQ;
         ACQ:     if (!ddr.busy) state_d = ISSUE;
         ISSUE: begin
            read_c = 1'b1;
            if (!ddr.busy) state_d = FILL;
         end
         FILL:    if (last_beat) state_d = FILL_DONE;
         RESP: begin
            ready_c = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef DDR_ROM_CACHE_CRITICAL_WORD_EN
      ready_c = ready_c | early_rdy_q;
`endif
   end

   // Control state: FSM, valid bits, beat counters, pending invalidate, response data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         beat_cnt_q <= '0;
         beat_num_q <= '0;
         pend_q     <= 1'b0;
         data_q     <= '0;
`ifdef DDR_ROM_CACHE_CRITICAL_WORD_EN
         early_rdy_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
`ifdef DDR_ROM_CACHE_CRITICAL_WORD_EN
         early_rdy_q <= beat_in && (beat_num_q == 2'd0);
`endif
         if (start_hit)
            data_q <= hw_sel(line_mem[{req_idx, req_beat}], req_hw);
         if (start_miss) begin
            valid_q[req_idx] <= 1'b0;
            beat_cnt_q       <= start_beat;
            beat_num_q       <= 2'd0;
            pend_q           <= 1'b0;
         end
         if (beat_in) begin
            beat_cnt_q <= beat_cnt_q + 2'd1;
            beat_num_q <= beat_num_q + 2'd1;
            if (beat_cnt_q == lat_beat)
               data_q <= hw_sel(ddr.rdata, lat_hw);
         end
         if (last_beat && !pend_q && !invalidate)
            valid_q[lat_idx] <= 1'b1;
         if (busy_state && invalidate)
            pend_q <= 1'b1;
         if (invalidate)
            valid_q <= '0;
      end
   end

   // Storage: latched miss address, line data and tags
   always_ff @(posedge clk) begin
      if (start_miss)
         lat_addr <= addr;
      if (beat_in)
         line_mem[{lat_idx, beat_cnt_q}] <= ddr.rdata;
      if (last_beat)
         tag_mem[lat_idx] <= lat_tag;
   end
endmodule

// File: tb/tb_ddr_rom_cache.sv
// Directed bench for ddr_rom_cache: hits, misses, conflicts, invalidation, arbiter stalls, reset.
module tb_ddr_rom_cache;
   localparam int ADDR_W = 24;
`ifdef DDR_ROM_CACHE_CRITICAL_WORD_EN
   localparam int RDY_LAT = 1;
`else
   localparam int RDY_LAT = 4;
`endif

   typedef struct {
      int          rdy_n;
      logic [15:0] rdy_data;
      int          rdy_cyc;
      int          acq_n;
      int          acq_gap;
      int          rd_n;
      int          rd_cyc;
      int          rd_busy;
      logic [31:0] rd_addr;
      logic [7:0]  burstcnt;
      int          first_beat;
      bit          tmo;
   } res_t;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              req = 1'b0;
   logic              invalidate = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [15:0]       data;
   logic              ready;
   int                n_checks = 0;
   int                n_fail = 0;
   logic [63:0]       base_beat [4];

   ddr_if ddr();

   ddr_rom_cache #(.BASE_ADDR(32'h3000_0000), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ddr        (ddr),
      .req        (req),
      .addr       (addr),
      .invalidate (invalidate),
      .data       (data),
      .ready      (ready)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
      $fatal(1);
   end

   // One fetch with a simple arbiter/DDR model; inv_mode 1 = invalidate with req, 2 = during 2nd beat.
   task automatic fetch(input logic [ADDR_W-1:0] a, input logic [15:0] pat, input int busy_n,
                        input int inv_mode, output res_t r);
      int cyc = 0;
      int bleft = 0;
      int k = 0;
      int post = 0;
      int busy_left = busy_n;
      int s = 0;
      bit pend = 0;
      bit seen_acq = 0;
      bit acq_end = 0;
      r = '{default: 0};
      @(negedge clk);
      req = 1'b1;
      addr = a;
      invalidate = (inv_mode == 1);
      while (post < 3) begin
         @(negedge clk);
         cyc++;
         invalidate = 1'b0;
         if (pend) begin
            pend = 0;
            bleft = 4;
            k = 0;
            s = int'(r.rd_addr[4:3]);
            r.first_beat = cyc;
         end
         if (bleft > 0) begin
            ddr.rdata_ready = 1'b1;
            ddr.rdata = base_beat[(s + k) % 4] ^ {4{pat}};
            if (inv_mode == 2 && k == 1) invalidate = 1'b1;
            k++;
            bleft--;
         end else begin
            ddr.rdata_ready = 1'b0;
         end
         if (ready) begin
            r.rdy_n++;
            r.rdy_data = data;
            r.rdy_cyc = cyc;
            req = 1'b0;
         end
         if (ddr.acquire) begin
            r.acq_n++;
            if (acq_end) r.acq_gap++;
            seen_acq = 1;
         end else if (seen_acq) begin
            acq_end = 1;
         end
         if (ddr.read) r.rd_n++;
         if (ddr.acquire && busy_left > 0) begin
            ddr.busy = 1'b1;
            busy_left--;
            if (ddr.read) r.rd_busy++;
         end else begin
            ddr.busy = 1'b0;
            if (ddr.read) begin
               r.rd_addr = ddr.addr;
               r.burstcnt = ddr.burstcnt;
               r.rd_cyc = cyc;
               pend = 1;
            end
         end
         if (r.rdy_n > 0 && !ddr.acquire && bleft == 0 && !pend) post++;
         if (cyc > 200) begin
            r.tmo = 1;
            post = 3;
         end
      end
      req = 1'b0;
      invalidate = 1'b0;
      ddr.busy = 1'b0;
      ddr.rdata_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      ddr.busy = 1'b0;
      ddr.rdata_ready = 1'b0;
      ddr.rdata = '0;
      repeat (3) @(negedge clk);
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
      n_checks++; if (data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", data); end
      n_checks++; if (ddr.acquire !== 1'b0) begin n_fail++; $display("FAIL reset_acquire: got %b expected 0", ddr.acquire); end
      n_checks++; if (ddr.read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b expected 0", ddr.read); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_miss_fill();
      res_t r;
      fetch(24'h000102, 16'h0000, 0, 0, r);
      n_checks++; if (r.tmo !== 1'b0) begin n_fail++; $display("FAIL miss_timeout: got %b expected 0", r.tmo); end
      n_checks++; if (r.rd_n !== 1) begin n_fail++; $display("FAIL miss_read_cycles: got %0d expected 1", r.rd_n); end
      n_checks++; if (r.rd_addr !== 32'h3000_0100) begin n_fail++; $display("FAIL miss_addr: got %h expected 30000100", r.rd_addr); end
      n_checks++; if (r.burstcnt !== 8'd4) begin n_fail++; $display("FAIL miss_burstcnt: got %0d expected 4", r.burstcnt); end
      n_checks++; if (r.rdy_data !== 16'h2222) begin n_fail++; $display("FAIL miss_data: got %h expected 2222", r.rdy_data); end
      n_checks++; if (r.rdy_n !== 1) begin n_fail++; $display("FAIL miss_ready_count: got %0d expected 1", r.rdy_n); end
      n_checks++; if (r.rd_cyc !== 2) begin n_fail++; $display("FAIL miss_read_latency: got %0d expected 2", r.rd_cyc); end
      n_checks++; if (r.rdy_cyc !== r.first_beat + RDY_LAT) begin n_fail++; $display("FAIL miss_ready_latency: got %0d expected %0d", r.rdy_cyc, r.first_beat + RDY_LAT); end
      n_checks++; if (r.acq_n !== 6) begin n_fail++; $display("FAIL miss_acquire_cycles: got %0d expected 6", r.acq_n); end
      n_checks++; if (ddr.write !== 1'b0) begin n_fail++; $display("FAIL const_write: got %b expected 0", ddr.write); end
      n_checks++; if (ddr.byteenable !== 8'hFF) begin n_fail++; $display("FAIL const_byteenable: got %h expected ff", ddr.byteenable); end
      n_checks++; if (ddr.wdata !== 64'h0) begin n_fail++; $display("FAIL const_wdata: got %h expected 0", ddr.wdata); end
   endtask

   task automatic test_hit();
      res_t r;
      fetch(24'h000104, 16'h0000, 0, 0, r);
      n_checks++; if (r.acq_n !== 0) begin n_fail++; $display("FAIL hit_acquire: got %0d expected 0", r.acq_n); end
      n_checks++; if (r.rdy_cyc !== 1) begin n_fail++; $display("FAIL hit_latency: got %0d expected 1", r.rdy_cyc); end
      n_checks++; if (r.rdy_data !== 16'h3333) begin n_fail++; $display("FAIL hit_data: got %h expected 3333", r.rdy_data); end
      n_checks++; if (r.rdy_n !== 1) begin n_fail++; $display("FAIL hit_ready_count: got %0d expected 1", r.rdy_n); end
      fetch(24'h00011C, 16'h0000, 0, 0, r);
      n_checks++; if (r.rdy_data !== 16'hFFFF) begin n_fail++; $display("FAIL hit_beat3_data: got %h expected ffff", r.rdy_data); end
      n_checks++; if (r.acq_n !== 0) begin n_fail++; $display("FAIL hit_beat3_acquire: got %0d expected 0", r.acq_n); end
   endtask

   task automatic test_conflict();
      res_t r;
      fetch(24'h000180, 16'h00A0, 0, 0, r);
      n_checks++; if (r.acq_n !== 6) begin n_fail++; $display("FAIL conflict_miss: got %0d expected 6", r.acq_n); end
      n_checks++; if (r.rd_addr !== 32'h3000_0180) begin n_fail++; $display("FAIL conflict_addr: got %h expected 30000180", r.rd_addr); end
      n_checks++; if (r.rdy_data !== 16'h11B1) begin n_fail++; $display("FAIL conflict_data: got %h expected 11b1", r.rdy_data); end
      fetch(24'h000100, 16'h0500, 0, 0, r);
      n_checks++; if (r.acq_n !== 6) begin n_fail++; $display("FAIL conflict_remiss: got %0d expected 6", r.acq_n); end
      n_checks++; if (r.rdy_data !== 16'h1411) begin n_fail++; $display("FAIL conflict_redata: got %h expected 1411", r.rdy_data); end
   endtask

   task automatic test_invalidate();
      res_t r;
      fetch(24'h000200, 16'h0030, 0, 2, r);
      n_checks++; if (r.rdy_n !== 1) begin n_fail++; $display("FAIL inv_fill_ready: got %0d expected 1", r.rdy_n); end
      n_checks++; if (r.rdy_data !== 16'h1121) begin n_fail++; $display("FAIL inv_fill_data: got %h expected 1121", r.rdy_data); end
      fetch(24'h000200, 16'h0000, 0, 0, r);
      n_checks++; if (r.acq_n !== 6) begin n_fail++; $display("FAIL inv_refetch_miss: got %0d expected 6", r.acq_n); end
      n_checks++; if (r.rdy_data !== 16'h1111) begin n_fail++; $display("FAIL inv_refetch_data: got %h expected 1111", r.rdy_data); end
      fetch(24'h000204, 16'h0007, 0, 1, r);
      n_checks++; if (r.acq_n !== 6) begin n_fail++; $display("FAIL inv_with_req_miss: got %0d expected 6", r.acq_n); end
      n_checks++; if (r.rdy_data !== 16'h3334) begin n_fail++; $display("FAIL inv_with_req_data: got %h expected 3334", r.rdy_data); end
   endtask

   task automatic test_back_to_back();
      int cnt = 0;
      int acq = 0;
      logic [15:0] last = '0;
      @(negedge clk);
      req = 1'b1;
      addr = 24'h000204;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ready) begin cnt++; last = data; end
         if (ddr.acquire) acq++;
      end
      req = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (cnt !== 4) begin n_fail++; $display("FAIL b2b_ready_count: got %0d expected 4", cnt); end
      n_checks++; if (acq !== 0) begin n_fail++; $display("FAIL b2b_acquire: got %0d expected 0", acq); end
      n_checks++; if (last !== 16'h3334) begin n_fail++; $display("FAIL b2b_data: got %h expected 3334", last); end
   endtask

   task automatic test_busy();
      res_t r;
      fetch(24'h000300, 16'h0900, 10, 0, r);
      n_checks++; if (r.rd_busy !== 0) begin n_fail++; $display("FAIL busy_read_early: got %0d expected 0", r.rd_busy); end
      n_checks++; if (r.acq_n !== 16) begin n_fail++; $display("FAIL busy_acquire_cycles: got %0d expected 16", r.acq_n); end
      n_checks++; if (r.acq_gap !== 0) begin n_fail++; $display("FAIL busy_acquire_gap: got %0d expected 0", r.acq_gap); end
      n_checks++; if (r.rd_cyc !== 12) begin n_fail++; $display("FAIL busy_read_cycle: got %0d expected 12", r.rd_cyc); end
      n_checks++; if (r.rd_n !== 1) begin n_fail++; $display("FAIL busy_read_count: got %0d expected 1", r.rd_n); end
      n_checks++; if (r.rdy_data !== 16'h1811) begin n_fail++; $display("FAIL busy_data: got %h expected 1811", r.rdy_data); end
   endtask

   task automatic test_reset_midburst();
      res_t r;
      bit seen = 0;
      logic pre_acq;
      int rdy = 0;
      int acq = 0;
      @(negedge clk);
      req = 1'b1;
      addr = 24'h000080;
      ddr.busy = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (ddr.read) seen = 1;
      end
      req = 1'b0;
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL midrst_read_seen: got %b expected 1", seen); end
      @(negedge clk);
      ddr.rdata_ready = 1'b1;
      ddr.rdata = 64'h0BAD_0BAD_0BAD_0BAD;
      @(negedge clk);
      ddr.rdata_ready = 1'b0;
      pre_acq = ddr.acquire;
      reset_n = 1'b0;
      #1;
      n_checks++; if (pre_acq !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_acquire: got %b expected 1", pre_acq); end
      n_checks++; if (ddr.acquire !== 1'b0) begin n_fail++; $display("FAIL midrst_acquire: got %b expected 0", ddr.acquire); end
      n_checks++; if (ddr.read !== 1'b0) begin n_fail++; $display("FAIL midrst_read: got %b expected 0", ddr.read); end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         ddr.rdata_ready = (i < 3);
         if (ready) rdy++;
         if (ddr.acquire) acq++;
      end
      ddr.rdata_ready = 1'b0;
      n_checks++; if (rdy !== 0) begin n_fail++; $display("FAIL midrst_stray_ready: got %0d expected 0", rdy); end
      n_checks++; if (acq !== 0) begin n_fail++; $display("FAIL midrst_stray_acquire: got %0d expected 0", acq); end
      fetch(24'h000300, 16'h0000, 0, 0, r);
      n_checks++; if (r.acq_n !== 6) begin n_fail++; $display("FAIL midrst_valid_cleared: got %0d expected 6", r.acq_n); end
   endtask

`ifdef DDR_ROM_CACHE_CRITICAL_WORD_EN
   task automatic test_critical_word();
      res_t r;
      fetch(24'h000118, 16'h0060, 0, 0, r);
      n_checks++; if (r.rd_addr !== 32'h3000_0118) begin n_fail++; $display("FAIL cw_addr: got %h expected 30000118", r.rd_addr); end
      n_checks++; if (r.rdy_data !== 16'hDDBD) begin n_fail++; $display("FAIL cw_data: got %h expected ddbd", r.rdy_data); end
      n_checks++; if (r.rdy_cyc !== r.first_beat + 1) begin n_fail++; $display("FAIL cw_latency: got %0d expected %0d", r.rdy_cyc, r.first_beat + 1); end
      n_checks++; if (r.rdy_n !== 1) begin n_fail++; $display("FAIL cw_ready_count: got %0d expected 1", r.rdy_n); end
      fetch(24'h000100, 16'h0000, 0, 0, r);
      n_checks++; if (r.acq_n !== 0) begin n_fail++; $display("FAIL cw_hit_acquire: got %0d expected 0", r.acq_n); end
      n_checks++; if (r.rdy_data !== 16'h1171) begin n_fail++; $display("FAIL cw_hit_data: got %h expected 1171", r.rdy_data); end
      fetch(24'h000110, 16'h0000, 0, 0, r);
      n_checks++; if (r.rdy_data !== 16'h99F9) begin n_fail++; $display("FAIL cw_hit_beat2: got %h expected 99f9", r.rdy_data); end
   endtask
`endif

   initial begin
      base_beat[0] = 64'h4444_3333_2222_1111;
      base_beat[1] = 64'h8888_7777_6666_5555;
      base_beat[2] = 64'hCCCC_BBBB_AAAA_9999;
      base_beat[3] = 64'h0000_FFFF_EEEE_DDDD;
      ddr.busy = 1'b0;
      ddr.rdata_ready = 1'b0;
      ddr.rdata = '0;
      test_reset();
      test_miss_fill();
      test_hit();
      test_conflict();
      test_invalidate();
      test_back_to_back();
      test_busy();
      test_reset_midburst();
`ifdef DDR_ROM_CACHE_CRITICAL_WORD_EN
      test_critical_word();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
